// File: rtl/wb_uart_fifo.sv
// wb_uart_fifo: Wishbone-attached UART with byte FIFOs on the TX and RX paths.
// Even-parity framing is compiled in only when WB_UART_FIFO_PARITY_EN is defined;
// without it every frame is 8N1, CTRL[2] reads 0 and parity_err never sets.

module wb_uart_fifo_q #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // Pointer advance; the extra MSB tells a full FIFO from an empty one.
    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, push_i};
        rd_d = rd_q + {{AW{1'b0}}, pop_i};
    end

    // Pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end
endmodule

module wb_uart_fifo #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        irq_o
);
`ifdef WB_UART_FIFO_PARITY_EN
    localparam logic PAR_SUP = 1'b1;
`else
    localparam logic PAR_SUP = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4} uart_state_e;

    logic        ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [3:0]  sticky_q, sticky_d, clr_s;
    logic [7:0]  status_s, tx_head_s, rx_head_s;
    logic        req_s, par_on_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic        tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic        tx_push_ok_s, rx_push_ok_s, tx_ovf_set_s, rx_ovr_set_s, fe_set_s, pe_set_s;
    logic        unused_s;
    uart_state_e txs_q, txs_d, rxs_q, rxs_d;
    logic [15:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d, rcnt_q, rcnt_d, rdiv_q, rdiv_d;
    logic [2:0]  tbit_q, tbit_d, rbit_q, rbit_d;
    logic [7:0]  tbyte_q, tbyte_d, rbyte_q, rbyte_d;
    logic        tx_q, tx_d, tend_s, load_s, rperr_q, rperr_d, rx_m_q, rx_s_q, rend_s, rhalf_s;

    assign unused_s     = ^wb_dat_i[31:16];
    assign req_s        = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign par_on_s     = ctrl_q[2];
    assign status_s     = {sticky_q, rx_full_s, rx_empty_s, tx_full_s, tx_empty_s};
    assign tx_push_ok_s = tx_push_s & (~tx_full_s | tx_pop_s);
    assign tx_ovf_set_s = tx_push_s & tx_full_s & ~tx_pop_s;
    assign rx_push_ok_s = rx_push_s & (~rx_full_s | rx_pop_s);
    assign rx_ovr_set_s = rx_push_s & rx_full_s & ~rx_pop_s;
    assign pe_set_s     = rx_push_s & rperr_q;
    assign tend_s       = (tcnt_q == tdiv_q - 16'd1);
    assign rend_s       = (rcnt_q == rdiv_q - 16'd1);
    assign rhalf_s      = (rcnt_q == {1'b0, rdiv_q[15:1]} - 16'd1);

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_stall_o = 1'b0;
    assign uart_tx_o  = tx_q;
    assign irq_o      = irq_q;

    wb_uart_fifo_q #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_push_ok_s), .pop_i(tx_pop_s),
        .din_i(wb_dat_i[7:0]), .head_o(tx_head_s), .empty_o(tx_empty_s), .full_o(tx_full_s)
    );

    wb_uart_fifo_q #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push_ok_s), .pop_i(rx_pop_s),
        .din_i(rbyte_q), .head_o(rx_head_s), .empty_o(rx_empty_s), .full_o(rx_full_s)
    );

    // Bus decode: one-cycle ack/err, read mux and register side effects.
    always_comb begin
        ack_d = 1'b0; err_d = 1'b0; dat_d = 32'h0; div_d = div_q; ctrl_d = ctrl_q;
        clr_s = 4'h0; tx_push_s = 1'b0; rx_pop_s = 1'b0;
        if (req_s) begin
            if (wb_adr_i[2]) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                case (wb_adr_i[1:0])
                    2'd0: if (wb_we_i) tx_push_s = 1'b1;
                          else begin
                              rx_pop_s = ~rx_empty_s;
                              dat_d    = rx_empty_s ? 32'h0 : {24'h0, rx_head_s};
                          end
                    2'd1: if (wb_we_i) clr_s = wb_dat_i[7:4]; else dat_d = {24'h0, status_s};
                    2'd2: if (wb_we_i) div_d = (wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb_dat_i[15:0];
                          else dat_d = {16'h0, div_q};
                    2'd3: if (wb_we_i) ctrl_d = {wb_dat_i[2] & PAR_SUP, wb_dat_i[1:0]};
                          else dat_d = {29'h0, ctrl_q};
                    default: dat_d = 32'h0;
                endcase
            end
        end else begin
            dat_d = 32'h0;
        end
    end

    // Sticky error flags (set wins over clear) and the interrupt level.
    always_comb begin
        sticky_d = (sticky_q & ~clr_s) | {pe_set_s, fe_set_s, rx_ovr_set_s, tx_ovf_set_s};
        irq_d    = (ctrl_q[0] & ~rx_empty_s) | (ctrl_q[1] & tx_empty_s);
    end

    // Bus-facing and configuration registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0; err_q <= 1'b0; dat_q <= 32'h0; div_q <= DIV_RESET;
            ctrl_q <= 3'h0; sticky_q <= 4'h0; irq_q <= 1'b0;
        end else begin
            ack_q <= ack_d; err_q <= err_d; dat_q <= dat_d; div_q <= div_d;
            ctrl_q <= ctrl_d; sticky_q <= sticky_d; irq_q <= irq_d;
        end
    end

    // TX next state: each state lasts one latched divisor; STOP chains straight into START.
    always_comb begin
        txs_d = txs_q; tcnt_d = tcnt_q + 16'd1; tdiv_d = tdiv_q; tbit_d = tbit_q;
        tbyte_d = tbyte_q; tx_d = tx_q; tx_pop_s = 1'b0; load_s = 1'b0;
        case (txs_q)
            S_IDLE: begin
                tcnt_d = 16'd0;
                if (!tx_empty_s) load_s = 1'b1; else tx_d = 1'b1;
            end
            S_START: if (tend_s) begin
                txs_d = S_DATA; tcnt_d = 16'd0; tbit_d = 3'd0; tx_d = tbyte_q[0];
            end else txs_d = S_START;
            S_DATA: if (tend_s) begin
                tcnt_d = 16'd0;
                if (tbit_q == 3'd7) begin
                    if (par_on_s) begin txs_d = S_PAR;  tx_d = ^tbyte_q; end
                    else          begin txs_d = S_STOP; tx_d = 1'b1;     end
                end else begin
                    tbit_d = tbit_q + 3'd1; tx_d = tbyte_q[tbit_q + 3'd1];
                end
            end else txs_d = S_DATA;
            S_PAR: if (tend_s) begin
                txs_d = S_STOP; tcnt_d = 16'd0; tx_d = 1'b1;
            end else txs_d = S_PAR;
            S_STOP: if (tend_s) begin
                if (!tx_empty_s) load_s = 1'b1;
                else begin txs_d = S_IDLE; tcnt_d = 16'd0; tx_d = 1'b1; end
            end else txs_d = S_STOP;
            default: begin txs_d = S_IDLE; tcnt_d = 16'd0; tx_d = 1'b1; end
        endcase
        if (load_s) begin
            txs_d = S_START; tx_pop_s = 1'b1; tbyte_d = tx_head_s;
            tdiv_d = div_q; tcnt_d = 16'd0; tx_d = 1'b0;
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    // TX state registers; tx_q resets high so the line idles at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txs_q <= S_IDLE; tcnt_q <= 16'd0; tdiv_q <= DIV_RESET; tbit_q <= 3'd0;
            tbyte_q <= 8'h0; tx_q <= 1'b1;
        end else begin
            txs_q <= txs_d; tcnt_q <= tcnt_d; tdiv_q <= tdiv_d; tbit_q <= tbit_d;
            tbyte_q <= tbyte_d; tx_q <= tx_d;
        end
    end

    // RX next state: validate start at half a bit, then sample mid-bit every divisor.
    always_comb begin
        rxs_d = rxs_q; rcnt_d = rcnt_q + 16'd1; rdiv_d = rdiv_q; rbit_d = rbit_q;
        rbyte_d = rbyte_q; rperr_d = rperr_q; rx_push_s = 1'b0; fe_set_s = 1'b0;
        case (rxs_q)
            S_IDLE: begin
                rcnt_d = 16'd0;
                if (!rx_s_q) begin rxs_d = S_START; rdiv_d = div_q; rperr_d = 1'b0; end
                else rxs_d = S_IDLE;
            end
            S_START: if (rhalf_s) begin
                rcnt_d = 16'd0; rbit_d = 3'd0; rxs_d = rx_s_q ? S_IDLE : S_DATA;
            end else rxs_d = S_START;
            S_DATA: if (rend_s) begin
                rcnt_d = 16'd0; rbyte_d[rbit_q] = rx_s_q;
                if (rbit_q == 3'd7) rxs_d = par_on_s ? S_PAR : S_STOP;
                else rbit_d = rbit_q + 3'd1;
            end else rxs_d = S_DATA;
            S_PAR: if (rend_s) begin
                rcnt_d = 16'd0; rperr_d = rx_s_q ^ (^rbyte_q); rxs_d = S_STOP;
            end else rxs_d = S_PAR;
            S_STOP: if (rend_s) begin
                rcnt_d = 16'd0; rxs_d = S_IDLE;
                if (!rx_s_q) fe_set_s = 1'b1; else rx_push_s = 1'b1;
            end else rxs_d = S_STOP;
            default: begin rxs_d = S_IDLE; rcnt_d = 16'd0; end
        endcase
    end

    // RX synchroniser and state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_m_q <= 1'b1; rx_s_q <= 1'b1; rxs_q <= S_IDLE; rcnt_q <= 16'd0;
            rdiv_q <= DIV_RESET; rbit_q <= 3'd0; rbyte_q <= 8'h0; rperr_q <= 1'b0;
        end else begin
            rx_m_q <= uart_rx_i; rx_s_q <= rx_m_q; rxs_q <= rxs_d; rcnt_q <= rcnt_d;
            rdiv_q <= rdiv_d; rbit_q <= rbit_d; rbyte_q <= rbyte_d; rperr_q <= rperr_d;
        end
    end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Self-checking bench for wb_uart_fifo with a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_uart_fifo;
    localparam int DEPTH = 4;
    localparam int DIVB  = 8;

    logic clk = 1'b0;
    logic rst, cyc, stb, we, ack, err, stall, rx_drv, loop_en, rx_line, tx, irq;
    logic [2:0]  adr;
    logic [31:0] dat_w, dat_r;
    int errors = 0;
    int checks = 0;

    logic [7:0] rxq[$];
    logic m_txovf = 1'b0, m_rxovr = 1'b0, m_fe = 1'b0, m_pe = 1'b0;

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx : rx_drv;

    wb_uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd868)) dut (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_ack_o(ack),
        .wb_err_o(err), .wb_stall_o(stall), .uart_rx_i(rx_line), .uart_tx_o(tx), .irq_o(irq)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone transfer; returns data/ack/err seen one edge after the request.
    task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic ak, output logic er);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        tick();
        rd = dat_r; ak = ack; er = err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    // Drive one serial frame onto the RX line at DIVB cycles per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_on, input logic par_bit);
        rx_drv = 1'b0; repeat (DIVB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i]; repeat (DIVB) tick();
        end
        if (par_on) begin
            rx_drv = par_bit; repeat (DIVB) tick();
        end
        rx_drv = stop; repeat (DIVB) tick();
        rx_drv = 1'b1; repeat (20) tick();
    endtask

    // Expected STATUS from the model (TX path assumed not full).
    function automatic logic [31:0] exp_status(input logic txe);
        return {24'h0, m_pe, m_fe, m_rxovr, m_txovf, (rxq.size() == DEPTH), (rxq.size() == 0), 1'b0, txe};
    endfunction

    task automatic test_reset();
        logic [31:0] rd; logic ak, er;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0; dat_w = 32'h0;
        rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b need 1", tx); end
        checks++; if ({ack, err, irq} !== 3'b000) begin errors++; $display("FAIL rst_outs: got %b need 000", {ack, err, irq}); end
        checks++; if (dat_r !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h need 0", dat_r); end
        rst = 1'b0; tick();
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h5 || ak !== 1'b1) begin errors++; $display("FAIL rst_status: got %h ack %b need 5 ack 1", rd, ak); end
        wb_xfer(1'b0, 3'd2, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'd868) begin errors++; $display("FAIL rst_div: got %0d need 868", rd); end
        wb_xfer(1'b0, 3'd3, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h need 0", rd); end
    endtask

    task automatic test_div();
        logic [31:0] rd, v; logic ak, er;
        wb_xfer(1'b1, 3'd2, 32'd2, rd, ak, er);
        wb_xfer(1'b0, 3'd2, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL div_min2: got %0d need 4", rd); end
        wb_xfer(1'b1, 3'd2, 32'd3, rd, ak, er);
        wb_xfer(1'b0, 3'd2, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL div_min3: got %0d need 4", rd); end
        v = $urandom_range(4, 5000);
        wb_xfer(1'b1, 3'd2, v | 32'hABCD_0000, rd, ak, er);
        wb_xfer(1'b0, 3'd2, 32'h0, rd, ak, er);
        checks++; if (rd !== v) begin errors++; $display("FAIL div_rand: got %0d need %0d", rd, v); end
        wb_xfer(1'b1, 3'd2, DIVB, rd, ak, er);
        wb_xfer(1'b0, 3'd2, 32'h0, rd, ak, er);
        checks++; if (rd !== DIVB) begin errors++; $display("FAIL div_8: got %0d need %0d", rd, DIVB); end
    endtask

    task automatic test_tx_wave();
        logic [31:0] rd; logic ak, er; logic [7:0] b; logic [9:0] frame;
        for (int n = 0; n < 2; n++) begin
            b = (n == 0) ? 8'h55 : 8'($urandom);
            frame = {1'b1, b, 1'b0};
            wb_xfer(1'b1, 3'd0, {24'h0, b}, rd, ak, er);
            for (int i = 0; i < 10 * DIVB; i++) begin
                checks++;
                if (tx !== frame[i / DIVB]) begin
                    errors++; $display("FAIL tx_wave byte %h cycle %0d: got %b need %b", b, i, tx, frame[i / DIVB]);
                end
                tick();
            end
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b need 1", tx); end
            wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
            checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL tx_status: got %h need %h", rd, exp_status(1'b1)); end
        end
    endtask

    task automatic test_loopback();
        logic [31:0] rd; logic ak, er; logic [7:0] b0, b1; logic [7:0] e;
        loop_en = 1'b1;
        for (int n = 0; n < 2; n++) begin
            b0 = (n == 0) ? 8'hA3 : 8'($urandom);
            b1 = (n == 0) ? 8'h3C : 8'($urandom);
            wb_xfer(1'b1, 3'd0, {24'h0, b0}, rd, ak, er);
            wb_xfer(1'b1, 3'd0, {24'h0, b1}, rd, ak, er);
            rxq.push_back(b0); rxq.push_back(b1);
            repeat (200) tick();
            for (int k = 0; k < 2; k++) begin
                e = rxq.pop_front();
                wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
                checks++; if (rd !== {24'h0, e}) begin errors++; $display("FAIL loop_data: got %h need %h", rd, e); end
            end
            wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
            checks++; if (rd !== 32'h0 || ak !== 1'b1) begin errors++; $display("FAIL loop_empty_read: got %h ack %b need 0 ack 1", rd, ak); end
            wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
            checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL loop_status: got %h need %h", rd, exp_status(1'b1)); end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ak, er; logic [7:0] b; logic [7:0] e;
        loop_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            wb_xfer(1'b1, 3'd0, {24'h0, b}, rd, ak, er);
            rxq.push_back(b);
        end
        repeat (10 * DIVB - 1 - 6) tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_stop: got %b need 1", tx); end
        tick();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_next_start: got %b need 0", tx); end
        repeat (300) tick();
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL b2b_full_status: got %h need %h", rd, exp_status(1'b1)); end
        while (rxq.size() > 0) begin
            e = rxq.pop_front();
            wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
            checks++; if (rd !== {24'h0, e}) begin errors++; $display("FAIL b2b_data: got %h need %h", rd, e); end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_tx_ovf();
        logic [31:0] rd; logic ak, er;
        for (int n = 0; n < 6; n++) wb_xfer(1'b1, 3'd0, $urandom, rd, ak, er);
        m_txovf = 1'b1;
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h16) begin errors++; $display("FAIL txovf_full: got %h need 16", rd); end
        repeat (5 * 10 * DIVB + 20) tick();
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL txovf_drained: got %h need %h", rd, exp_status(1'b1)); end
        wb_xfer(1'b1, 3'd1, 32'h10, rd, ak, er);
        m_txovf = 1'b0;
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL txovf_clear: got %h need 5", rd); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd; logic ak, er; logic [7:0] b; logic [7:0] e;
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, 1'b0);
            if (rxq.size() < DEPTH) rxq.push_back(b); else m_rxovr = 1'b1;
        end
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== exp_status(1'b1) || rd !== 32'h29) begin errors++; $display("FAIL ovr_status: got %h need %h", rd, exp_status(1'b1)); end
        while (rxq.size() > 0) begin
            e = rxq.pop_front();
            wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
            checks++; if (rd !== {24'h0, e}) begin errors++; $display("FAIL ovr_data: got %h need %h", rd, e); end
        end
        wb_xfer(1'b1, 3'd1, 32'h20, rd, ak, er);
        m_rxovr = 1'b0;
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL ovr_clear: got %h need 5", rd); end
    endtask

    task automatic test_frame_err();
        logic [31:0] rd; logic ak, er;
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        m_fe = 1'b1;
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL fe_status: got %h need %h", rd, exp_status(1'b1)); end
        wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fe_nopush: got %h need 0", rd); end
        for (int a = 4; a < 8; a += 1) begin
            wb_xfer(1'b0, 3'(a), 32'h0, rd, ak, er);
            checks++; if ({er, ak} !== 2'b10 || rd !== 32'h0) begin errors++; $display("FAIL unmapped_%0d: got err %b ack %b dat %h need err 1 ack 0 dat 0", a, er, ak, rd); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b need 0", err); end
        end
        wb_xfer(1'b1, 3'd1, 32'h40, rd, ak, er);
        m_fe = 1'b0;
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL fe_clear: got %h need 5", rd); end
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic ak, er; logic [7:0] b;
        wb_xfer(1'b1, 3'd3, 32'h2, rd, ak, er);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx: got %b need 1", irq); end
        wb_xfer(1'b1, 3'd3, 32'h1, rd, ak, er);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_empty: got %b need 0", irq); end
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b need 1", irq); end
        wb_xfer(1'b0, 3'd3, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_read: got %h need 1", rd); end
        wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
        checks++; if (rd !== {24'h0, b}) begin errors++; $display("FAIL irq_data: got %h need %h", rd, b); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b need 0", irq); end
        wb_xfer(1'b1, 3'd3, 32'hFFFF_FFFF, rd, ak, er);
        wb_xfer(1'b0, 3'd3, 32'h0, rd, ak, er);
`ifdef WB_UART_FIFO_PARITY_EN
        checks++; if (rd !== 32'h7) begin errors++; $display("FAIL ctrl_all: got %h need 7", rd); end
`else
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL ctrl_all: got %h need 3", rd); end
`endif
        wb_xfer(1'b1, 3'd3, 32'h0, rd, ak, er);
    endtask

`ifdef WB_UART_FIFO_PARITY_EN
    task automatic test_parity();
        logic [31:0] rd; logic ak, er; logic [7:0] b;
        wb_xfer(1'b1, 3'd3, 32'h4, rd, ak, er);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        m_pe = 1'b1; rxq.push_back(8'h07);
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== exp_status(1'b1)) begin errors++; $display("FAIL par_status: got %h need %h", rd, exp_status(1'b1)); end
        wb_xfer(1'b1, 3'd3, 32'h5, rd, ak, er);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL par_irq: got %b need 1", irq); end
        wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
        checks++; if (rd !== {24'h0, rxq.pop_front()}) begin errors++; $display("FAIL par_data: got %h need 07", rd); end
        wb_xfer(1'b1, 3'd1, 32'h80, rd, ak, er);
        m_pe = 1'b0;
        b = 8'($urandom);
        loop_en = 1'b1;
        wb_xfer(1'b1, 3'd0, {24'h0, b}, rd, ak, er);
        repeat (11 * DIVB + 20) tick();
        loop_en = 1'b0;
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL par_loop_status: got %h need 1", rd); end
        wb_xfer(1'b0, 3'd0, 32'h0, rd, ak, er);
        checks++; if (rd !== {24'h0, b}) begin errors++; $display("FAIL par_loop_data: got %h need %h", rd, b); end
        wb_xfer(1'b1, 3'd3, 32'h0, rd, ak, er);
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] rd; logic ak, er;
        for (int n = 0; n < 3; n++) wb_xfer(1'b1, 3'd0, $urandom, rd, ak, er);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_start: got %b need 0", tx); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx: got %b need 1", tx); end
        tick();
        rst = 1'b0;
        tick();
        wb_xfer(1'b0, 3'd1, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL mid_status: got %h need 5", rd); end
        wb_xfer(1'b0, 3'd2, 32'h0, rd, ak, er);
        checks++; if (rd !== 32'd868) begin errors++; $display("FAIL mid_div: got %0d need 868", rd); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx_idle: got %b need 1", tx); end
    endtask

    initial begin
        test_reset();
        test_div();
        test_tx_wave();
        test_loopback();
        test_back_to_back();
        test_tx_ovf();
        test_overrun();
        test_frame_err();
        test_irq();
`ifdef WB_UART_FIFO_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_uart_fifo.md
WB_UART_FIFO -- requirements
Module: wb_uart_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO; power of two, 2..256.
REQ-002 Parameter DIV_RESET, default 16'd868, reset value of the baud divisor in clock cycles per bit.
REQ-003 Ports, one per line:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  3  word address; byte address bits [4:2].
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error acknowledge.
- wb_stall_o  out  1  tied 0.
- uart_rx_i  in  1  serial input, asynchronous.
- uart_tx_o  out  1  serial output, idle high.
- irq_o  out  1  level interrupt.

Function
REQ-004 Register map: word 0 DATA, 1 STATUS, 2 DIV[15:0], 3 CTRL; words 4-7 unmapped.
REQ-005 Handshake: for cyc&stb&!ack, ack (mapped) or err (unmapped) is asserted for exactly one cycle on the next edge; the side effect occurs on that edge; wb_dat_o is valid with ack and 0 otherwise.
REQ-006 DATA write pushes wb_dat_i[7:0] into TX FIFO; write while full is dropped and sets STATUS.tx_ovf.
REQ-007 DATA read returns {24'h0, RX head} and pops; read while RX empty returns 0 with no pop.
REQ-008 STATUS bits: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_ovr, [6] frame_err, [7] parity_err; bits [7:4] sticky, cleared by writing 1 to STATUS.
REQ-009 DIV write takes effect at the next frame start; values below 4 are stored as 4.
REQ-010 CTRL bits: [0] rx_irq_en, [1] tx_irq_en, [2] parity_en; read back as stored.
REQ-011 irq_o = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty), registered, one-cycle latency.
REQ-012 TX FSM IDLE->START->DATA(8 bits, LSB first)->[PARITY]->STOP->IDLE; each state lasts DIV cycles; leaves IDLE the cycle after TX FIFO non-empty and pops on that transition; back-to-back frames with no idle gap.
REQ-013 RX: 2-flop synchroniser; RX FSM IDLE->START->DATA->[PARITY]->STOP; start validated at DIV/2 (returns to IDLE if high); bits sampled every DIV cycles thereafter.
REQ-014 STOP sampled low sets frame_err and discards the byte; otherwise byte pushed into RX FIFO; push while full drops the byte and sets rx_ovr.
REQ-015 Simultaneous push and pop on a full or empty FIFO: both performed, occupancy unchanged; pointers wrap modulo FIFO_DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-016 On rst_i: FIFOs empty, FSMs IDLE, DIV=DIV_RESET, CTRL=0, sticky bits 0, uart_tx_o=1, wb_ack_o=wb_err_o=0, wb_dat_o=0, irq_o=0.
REQ-017 Reset mid-frame aborts immediately; uart_tx_o high in the same cycle (asynchronous).

Configuration
REQ-018 Macro WB_UART_FIFO_PARITY_EN defined: parity_en=1 adds an even-parity bit after data; RX mismatch sets parity_err and the byte is still pushed.
REQ-019 Macro undefined: frames always 8N1; CTRL[2] reads 0; parity_err reads 0.

Verification
REQ-020 Reset, read STATUS -> 32'h0000_0005, DIV reads 868, uart_tx_o=1.
REQ-021 DIV=8, write DATA 0x55 -> uart_tx_o: 8 cycles low, then 0,1,0,1,0,1,0,1 reversed LSB-first (1,0,1,0,1,0,1,0), 8 cycles each, then high; tx_empty=1 afterwards.
REQ-022 DIV=8, tx looped to rx, write 0xA3, 0x3C -> RX FIFO yields 0xA3 then 0x3C; third DATA read returns 0, rx_empty=1.
REQ-023 FIFO_DEPTH=4, DIV=8: send 5 serial bytes without reading -> rx_full=1, rx_ovr=1, first 4 bytes read back intact; write STATUS 0x20 clears rx_ovr.
REQ-024 Serial frame with stop bit 0 -> frame_err=1, no push; read of word 5 -> wb_err_o one cycle, no ack.
REQ-025 With WB_UART_FIFO_PARITY_EN, CTRL=4, receive 0x07 with odd parity bit -> parity_err=1, 0x07 in RX FIFO; CTRL=1 -> irq_o=1 within 2 cycles.
